// File: rtl/urv_wb_stage_if.sv
// Data-memory completion bus seen by the uRV writeback stage.
// The memory side drives it (master); the writeback stage consumes it (slave).
interface urv_wb_stage_if;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic        dm_store_done_i;

  modport master (output dm_data_l_i, output dm_load_done_i, output dm_store_done_i);
  modport slave  (input  dm_data_l_i, input  dm_load_done_i, input  dm_store_done_i);
endinterface

// File: rtl/urv_wb_stage.sv
// uRV writeback stage: result select, load extraction, load/store completion wait, registered RF write.
// Optional bus watchdog (port w_bus_err_o) enabled by URV_WB_BUS_TIMEOUT_EN; g_timeout_cycles is its limit.
module urv_wb_stage #(
   parameter int unsigned g_timeout_cycles = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        x_valid_i,
   input  logic        x_load_i,
   input  logic        x_store_i,
   input  logic [2:0]  x_fun_i,
   input  logic [4:0]  x_rd_i,
   input  logic        x_rd_write_i,
   input  logic [31:0] x_rd_value_i,
   input  logic [1:0]  x_rd_source_i,
   input  logic [31:0] x_rd_shifter_i,
   input  logic [31:0] x_rd_multiply_i,
   input  logic [31:0] x_dm_addr_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   input  logic        dm_store_done_i,
   output logic        w_stall_req_o,
`ifdef URV_WB_BUS_TIMEOUT_EN
   output logic        w_bus_err_o,
`endif
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic        rf_rd_write_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_LOAD, S_WAIT_STORE} state_e;

   state_e      state_q, state_d;
   logic [2:0]  fun_q, fun_d;
   logic [4:0]  rd_q, rd_d;
   logic        rd_write_q, rd_write_d;
   logic [1:0]  addr_q, addr_d;
   logic [4:0]  rf_rd_q, rf_rd_d;
   logic [31:0] rf_rd_value_q, rf_rd_value_d;
   logic        rf_rd_write_q, rf_rd_write_d;
   logic        stall_req;
   logic        timeout_hit;
   logic        unused_addr;

   assign unused_addr = &{1'b0, x_dm_addr_i[31:2]};

   // Load data formatting: pick the addressed byte/half lane, then sign or zero extend.
   function automatic logic [31:0] load_extract(input logic [2:0]  fun,
                                                input logic [1:0]  addr,
                                                input logic [31:0] data);
      logic [7:0]  b;
      logic [15:0] h;
      case (addr)
         2'd0:    b = data[7:0];
         2'd1:    b = data[15:8];
         2'd2:    b = data[23:16];
         default: b = data[31:24];
      endcase
      h = addr[1] ? data[31:16] : data[15:0];
      case (fun)
         3'b000:  load_extract = {{24{b[7]}}, b};
         3'b001:  load_extract = {{16{h[15]}}, h};
         3'b010:  load_extract = data;
         3'b100:  load_extract = {24'h0, b};
         3'b101:  load_extract = {16'h0, h};
         default: load_extract = 32'h0;
      endcase
   endfunction

`ifdef URV_WB_BUS_TIMEOUT_EN
   localparam int CNT_W = (g_timeout_cycles > 255) ? 16 : 8;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q, bus_err_d;

   // The counter sits at zero in IDLE, so it is cleared on every WAIT entry.
   assign cnt_d       = (state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
   assign timeout_hit = (state_q != S_IDLE) && ((32'(cnt_q) + 32'd1) >= g_timeout_cycles);
   assign bus_err_d   = timeout_hit &&
                        (((state_q == S_WAIT_LOAD)  && !dm_load_done_i) ||
                         ((state_q == S_WAIT_STORE) && !dm_store_done_i));
   assign w_bus_err_o = bus_err_q;
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state logic: accept accesses in IDLE, wait for the done strobe, and compute the registered RF write.
   always_comb begin
      state_d       = state_q;
      fun_d         = fun_q;
      rd_d          = rd_q;
      rd_write_d    = rd_write_q;
      addr_d        = addr_q;
      rf_rd_d       = rf_rd_q;
      rf_rd_value_d = rf_rd_value_q;
      rf_rd_write_d = 1'b0;
      stall_req     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (x_valid_i && x_load_i) begin
               if (dm_load_done_i) begin
                  if (x_rd_write_i && (x_rd_i != 5'd0)) begin
                     rf_rd_write_d = 1'b1;
                     rf_rd_d       = x_rd_i;
                     rf_rd_value_d = load_extract(x_fun_i, x_dm_addr_i[1:0], dm_data_l_i);
                  end
               end else begin
                  fun_d      = x_fun_i;
                  rd_d       = x_rd_i;
                  rd_write_d = x_rd_write_i;
                  addr_d     = x_dm_addr_i[1:0];
                  state_d    = S_WAIT_LOAD;
                  stall_req  = 1'b1;
               end
            end else if (x_valid_i && x_store_i) begin
               if (!dm_store_done_i) begin
                  state_d   = S_WAIT_STORE;
                  stall_req = 1'b1;
               end
            end else if (x_valid_i && x_rd_write_i && (x_rd_i != 5'd0)) begin
               rf_rd_write_d = 1'b1;
               rf_rd_d       = x_rd_i;
               case (x_rd_source_i)
                  2'b01:   rf_rd_value_d = x_rd_shifter_i;
                  2'b10:   rf_rd_value_d = x_rd_multiply_i;
                  default: rf_rd_value_d = x_rd_value_i;
               endcase
            end
         end

         S_WAIT_LOAD: begin
            if (dm_load_done_i || timeout_hit) begin
               state_d = S_IDLE;
               if (rd_write_q && (rd_q != 5'd0)) begin
                  rf_rd_write_d = 1'b1;
                  rf_rd_d       = rd_q;
                  rf_rd_value_d = dm_load_done_i ? load_extract(fun_q, addr_q, dm_data_l_i) : 32'h0;
               end
            end else begin
               stall_req = 1'b1;
            end
         end

         S_WAIT_STORE: begin
            if (dm_store_done_i || timeout_hit) begin
               state_d = S_IDLE;
            end else begin
               stall_req = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= S_IDLE;
         fun_q         <= 3'b0;
         rd_q          <= 5'd0;
         rd_write_q    <= 1'b0;
         addr_q        <= 2'b0;
         rf_rd_q       <= 5'd0;
         rf_rd_value_q <= 32'h0;
         rf_rd_write_q <= 1'b0;
`ifdef URV_WB_BUS_TIMEOUT_EN
         cnt_q         <= '0;
         bus_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         fun_q         <= fun_d;
         rd_q          <= rd_d;
         rd_write_q    <= rd_write_d;
         addr_q        <= addr_d;
         rf_rd_q       <= rf_rd_d;
         rf_rd_value_q <= rf_rd_value_d;
         rf_rd_write_q <= rf_rd_write_d;
`ifdef URV_WB_BUS_TIMEOUT_EN
         cnt_q         <= cnt_d;
         bus_err_q     <= bus_err_d;
`endif
      end
   end

   assign w_stall_req_o = stall_req;
   assign rf_rd_o       = rf_rd_q;
   assign rf_rd_value_o = rf_rd_value_q;
   assign rf_rd_write_o = rf_rd_write_q;

endmodule

// File: tb/tb_urv_wb_stage.sv
// Self-checking bench for urv_wb_stage: directed cases then randomized transactions against a reference model.
// The DUT is built with g_timeout_cycles=4; with URV_WB_BUS_TIMEOUT_EN defined the watchdog is exercised.
module tb_urv_wb_stage;
   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        x_valid_i, x_load_i, x_store_i, x_rd_write_i;
   logic [2:0]  x_fun_i;
   logic [4:0]  x_rd_i;
   logic [31:0] x_rd_value_i, x_rd_shifter_i, x_rd_multiply_i, x_dm_addr_i;
   logic [1:0]  x_rd_source_i;
   logic [31:0] dm_data_l_i;
   logic        dm_load_done_i, dm_store_done_i;
   logic        w_stall_req_o, rf_rd_write_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_rd_value_o;
`ifdef URV_WB_BUS_TIMEOUT_EN
   logic        w_bus_err_o;
`endif

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   urv_wb_stage #(.g_timeout_cycles(4)) dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .x_valid_i       (x_valid_i),
      .x_load_i        (x_load_i),
      .x_store_i       (x_store_i),
      .x_fun_i         (x_fun_i),
      .x_rd_i          (x_rd_i),
      .x_rd_write_i    (x_rd_write_i),
      .x_rd_value_i    (x_rd_value_i),
      .x_rd_source_i   (x_rd_source_i),
      .x_rd_shifter_i  (x_rd_shifter_i),
      .x_rd_multiply_i (x_rd_multiply_i),
      .x_dm_addr_i     (x_dm_addr_i),
      .dm_data_l_i     (dm_data_l_i),
      .dm_load_done_i  (dm_load_done_i),
      .dm_store_done_i (dm_store_done_i),
      .w_stall_req_o   (w_stall_req_o),
`ifdef URV_WB_BUS_TIMEOUT_EN
      .w_bus_err_o     (w_bus_err_o),
`endif
      .rf_rd_o         (rf_rd_o),
      .rf_rd_value_o   (rf_rd_value_o),
      .rf_rd_write_o   (rf_rd_write_o)
   );

   // Free-running 10 ns clock.
   always #5 clk_i = ~clk_i;

   // Compare one observed value against its expectation and count the result.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
      end
   endtask

   // Reference load formatting: shift the addressed lane down, then sign/zero extend.
   function automatic logic [31:0] refLoad(input logic [2:0] fun, input logic [1:0] addr, input logic [31:0] word);
      logic [31:0] byte_sh, half_sh;
      byte_sh = word >> (8 * int'(addr));
      half_sh = word >> (addr[1] ? 16 : 0);
      case (fun)
         3'b000:  return 32'($signed(byte_sh[7:0]));
         3'b001:  return 32'($signed(half_sh[15:0]));
         3'b010:  return word;
         3'b100:  return 32'(byte_sh[7:0]);
         3'b101:  return 32'(half_sh[15:0]);
         default: return 32'h0;
      endcase
   endfunction

   // Drive every DUT input to its quiet value.
   task automatic idleInputs();
      x_valid_i = 1'b0; x_load_i = 1'b0; x_store_i = 1'b0; x_rd_write_i = 1'b0;
      x_fun_i = 3'b0; x_rd_i = 5'd0; x_rd_source_i = 2'b0;
      x_rd_value_i = 32'h0; x_rd_shifter_i = 32'h0; x_rd_multiply_i = 32'h0; x_dm_addr_i = 32'h0;
      dm_data_l_i = 32'h0; dm_load_done_i = 1'b0; dm_store_done_i = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   // kind: 0 = register op, 1 = load, 2 = store; lat = cycles before the done strobe.
   task automatic applyStimulus(input int kind, input logic [2:0] fun, input logic [4:0] rd,
                                input logic rd_write, input logic [1:0] src,
                                input logic [31:0] val, input logic [31:0] shf, input logic [31:0] mul,
                                input logic [31:0] addr, input logic [31:0] data, input int lat);
      logic        exp_wr;
      logic [31:0] exp_val;
      exp_wr = (kind != 2) && rd_write && (rd != 5'd0);
      if (kind == 1)      exp_val = refLoad(fun, addr[1:0], data);
      else if (src == 1)  exp_val = shf;
      else if (src == 2)  exp_val = mul;
      else                exp_val = val;

      x_valid_i = 1'b1; x_load_i = (kind == 1); x_store_i = (kind == 2);
      x_fun_i = fun; x_rd_i = rd; x_rd_write_i = rd_write; x_rd_source_i = src;
      x_rd_value_i = val; x_rd_shifter_i = shf; x_rd_multiply_i = mul; x_dm_addr_i = addr;
      if (kind == 0) begin
         #1 checkOutput("op_stall", 32'(w_stall_req_o), 32'd0);
      end else begin
         for (int k = 0; k < lat; k++) begin
            dm_load_done_i = 1'b0; dm_store_done_i = 1'b0; dm_data_l_i = $urandom;
            #1 checkOutput("wait_stall", 32'(w_stall_req_o), 32'd1);
            if (k > 0) checkOutput("wait_nowrite", 32'(rf_rd_write_o), 32'd0);
            @(posedge clk_i); #1;
            x_rd_i = 5'($urandom); x_fun_i = 3'($urandom); x_dm_addr_i = $urandom;
            x_rd_value_i = $urandom; x_rd_source_i = 2'($urandom); x_rd_write_i = 1'($urandom);
         end
         dm_data_l_i = data;
         dm_load_done_i = (kind == 1);
         dm_store_done_i = (kind == 2);
         #1 checkOutput("done_stall", 32'(w_stall_req_o), 32'd0);
      end
      @(posedge clk_i); #1;
      idleInputs();
      checkOutput("rf_write", 32'(rf_rd_write_o), 32'(exp_wr));
      if (exp_wr) begin
         checkOutput("rf_rd", 32'(rf_rd_o), 32'(rd));
         checkOutput("rf_value", rf_rd_value_o, exp_val);
      end
   endtask

   // Main test sequence: reset, directed cases, mid-wait reset, watchdog, random traffic.
   initial begin
      idleInputs();
      rst_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("rst_stall", 32'(w_stall_req_o), 32'd0);
      checkOutput("rst_rd", 32'(rf_rd_o), 32'd0);
      checkOutput("rst_value", rf_rd_value_o, 32'h0);
      checkOutput("rst_write", 32'(rf_rd_write_o), 32'd0);
      rst_n_i = 1'b1;
      nextCycle();

      $display("[TB] directed cases");
      applyStimulus(0, 3'b000, 5'd5,  1'b1, 2'b00, 32'h1234, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0, 32'h0, 0);
      applyStimulus(0, 3'b000, 5'd6,  1'b1, 2'b01, 32'h1111, 32'h2222_3333, 32'h4444, 32'h0, 32'h0, 0);
      applyStimulus(0, 3'b000, 5'd7,  1'b1, 2'b10, 32'h1111, 32'h2222, 32'h5555_6666, 32'h0, 32'h0, 0);
      applyStimulus(0, 3'b000, 5'd8,  1'b1, 2'b11, 32'h7777_8888, 32'h2222, 32'h3333, 32'h0, 32'h0, 0);
      applyStimulus(1, 3'b000, 5'd12, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h3, 32'h80FF_FF7F, 3);
      applyStimulus(1, 3'b101, 5'd13, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h2, 32'hBEEF_0000, 0);
      applyStimulus(2, 3'b010, 5'd14, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2);
      applyStimulus(1, 3'b010, 5'd0,  1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 1);
      applyStimulus(1, 3'b011, 5'd15, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1);
      applyStimulus(1, 3'b001, 5'd16, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h1, 32'h1234_8001, 2);

      dm_load_done_i = 1'b1; dm_store_done_i = 1'b1; dm_data_l_i = 32'h5A5A_5A5A;
      #1 checkOutput("stray_stall", 32'(w_stall_req_o), 32'd0);
      nextCycle();
      idleInputs();
      checkOutput("stray_write", 32'(rf_rd_write_o), 32'd0);

      $display("[TB] reset during load wait");
      applyStimulus(0, 3'b000, 5'd21, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      x_valid_i = 1'b1; x_load_i = 1'b1; x_fun_i = 3'b010; x_rd_i = 5'd7; x_rd_write_i = 1'b1;
      nextCycle();
      nextCycle();
      #2;
      rst_n_i = 1'b0;
      idleInputs();
      #1;
      checkOutput("midrst_stall", 32'(w_stall_req_o), 32'd0);
      checkOutput("midrst_rd", 32'(rf_rd_o), 32'd0);
      checkOutput("midrst_value", rf_rd_value_o, 32'h0);
      checkOutput("midrst_write", 32'(rf_rd_write_o), 32'd0);
      nextCycle();
      rst_n_i = 1'b1;
      nextCycle();
      dm_load_done_i = 1'b1; dm_data_l_i = 32'h1357_9BDF;
      #1 checkOutput("late_done_stall", 32'(w_stall_req_o), 32'd0);
      nextCycle();
      idleInputs();
      checkOutput("late_done_write", 32'(rf_rd_write_o), 32'd0);

`ifdef URV_WB_BUS_TIMEOUT_EN
      $display("[TB] bus watchdog");
      x_valid_i = 1'b1; x_load_i = 1'b1; x_fun_i = 3'b010; x_rd_i = 5'd9; x_rd_write_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 checkOutput("wd_stall", 32'(w_stall_req_o), 32'd1);
         checkOutput("wd_err_low", 32'(w_bus_err_o), 32'd0);
         nextCycle();
      end
      #1 checkOutput("wd_abort_stall", 32'(w_stall_req_o), 32'd0);
      nextCycle();
      idleInputs();
      checkOutput("wd_err", 32'(w_bus_err_o), 32'd1);
      checkOutput("wd_write", 32'(rf_rd_write_o), 32'd1);
      checkOutput("wd_rd", 32'(rf_rd_o), 32'd9);
      checkOutput("wd_value", rf_rd_value_o, 32'h0);
      nextCycle();
      checkOutput("wd_err_pulse", 32'(w_bus_err_o), 32'd0);
`endif

      $display("[TB] randomized transactions");
      for (int t = 0; t < 80; t++) begin
         applyStimulus(int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 5'($urandom),
                       ($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom, $urandom,
                       $urandom, $urandom, int'($urandom_range(0, 3)));
      end

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
